ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter XLEN, default 32, instruction/address width; taken from the shared config constant.
REQ-002 Parameter FQ_DEPTH, default 2, fetch-queue entries; legal values 2 or 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 pc_addr  input  XLEN  current PC from the PC register.
REQ-006 pc_write_en  output  1  PC register write strobe.
REQ-007 pc_write_addr  output  XLEN  next PC value to write.
REQ-008 imem_req  output  1  instruction RAM read request, one cycle per request.
REQ-009 imem_addr  output  XLEN  instruction RAM read address.
REQ-010 imem_rvalid  input  1  read data valid, 1 or more cycles after imem_req.
REQ-011 imem_rdata  input  XLEN  read data.
REQ-012 flush  input  1  one-cycle redirect (branch/jump/trap).
REQ-013 flush_addr  input  XLEN  redirect target.
REQ-014 inst_valid  output  1  queue head valid toward decoder.
REQ-015 inst_ready  input  1  decoder accepts head.
REQ-016 inst_data  output  XLEN  head instruction.
REQ-017 inst_pc  output  XLEN  head instruction address.
REQ-018 misalign_err  output  1  one-cycle pulse on misaligned redirect.

Function
REQ-019 FSM states: IDLE, FETCH, WAIT_RSP; IDLE -> FETCH unconditionally one cycle after reset release.
REQ-020 At most one request outstanding; the outstanding address is held in an internal req_pc register.
REQ-021 Issue condition: state FETCH, no flush, and (queue count + outstanding) < FQ_DEPTH.
REQ-022 On issue: imem_req=1, imem_addr=pc_addr, pc_write_en=1, pc_write_addr=pc_addr+4 (modulo 2^XLEN), req_pc<=pc_addr, FETCH -> WAIT_RSP; all in the same cycle.
REQ-023 WAIT_RSP: on imem_rvalid, push {req_pc, imem_rdata} into the queue and return to FETCH; the next issue occurs no earlier than the following cycle.
REQ-024 Best-case throughput: one instruction per 2 cycles with a 1-cycle RAM; pc_write_en is 0 in every cycle without an issue or flush.
REQ-025 Queue head is presented combinationally; a pop occurs on inst_valid & inst_ready; push and pop in the same cycle both occur.
REQ-026 Full queue: no issue; empty queue: inst_valid=0, inst_data/inst_pc hold their last value.
REQ-027 Flush: pc_write_en=1, pc_write_addr=flush_addr, queue cleared, a pop in that cycle is ignored, no issue that cycle, next state FETCH.
REQ-028 A flush while a request is outstanding sets a discard flag; the next imem_rvalid is dropped, not pushed; no issue while the discard flag is set.
REQ-029 A flush coinciding with imem_rvalid drops that response and sets no discard flag.
REQ-030 flush takes priority over any issue or pop in the same cycle.

Reset
REQ-031 While rst_n=0: state IDLE, queue empty, discard flag 0, req_pc 0; pc_write_en, imem_req, inst_valid, misalign_err 0; imem_addr, pc_write_addr, inst_data, inst_pc 0.
REQ-032 An assertion of rst_n mid-request abandons the request; a later imem_rvalid with no request outstanding is ignored.

Configuration
REQ-033 Macro IFU_ALIGN_CHECK_EN defined: a flush with flush_addr[1:0]!=0 pulses misalign_err for that cycle and writes {flush_addr[XLEN-1:2],2'b00}.
REQ-034 IFU_ALIGN_CHECK_EN undefined: flush_addr is passed unchanged and misalign_err is tied to 0.

Structure
REQ-035 FSM state encodings, the PC increment (4), and FQ_DEPTH legal values belong in the shared config file with XLEN.
REQ-036 The queue is a sub-module ifu_fetch_fifo (depth, push, pop, clear, count, head outputs); the FSM and PC logic stay in ifu_fetch.

Verification
REQ-037 Reset release, pc_addr=0x0, 1-cycle RAM -> imem_req at 0x0, 0x4, 0x8 on alternate cycles; inst_pc sequence 0x0, 0x4, 0x8.
REQ-038 inst_ready=0 with FQ_DEPTH=2 -> exactly 2 requests; imem_req stays 0 until the first pop.
REQ-039 Flush to 0x100 while the request at 0x8 is outstanding, 3-cycle RAM -> response for 0x8 dropped, first queued inst_pc=0x100.
REQ-040 flush and inst_ready=1 with a valid head in the same cycle -> queue empty next cycle, pc_write_addr=flush_addr, no pop counted.
REQ-041 IFU_ALIGN_CHECK_EN defined, flush_addr=0x102 -> misalign_err=1 for one cycle, pc_write_addr=0x100; undefined -> 0x102, misalign_err=0.
REQ-042 rst_n low during WAIT_RSP, then a stray imem_rvalid -> queue stays empty, inst_valid=0.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared configuration for the instruction fetch unit
package ifu_fetch_pkg;

  // Instruction and address width used by the fetch unit and its queue
  localparam int unsigned IFU_XLEN = 32;

  // Sequential PC step, one 32-bit instruction
  localparam int unsigned IFU_PC_INC = 4;

  // Fetch-queue depths the design supports (power of two, so pointers wrap naturally)
  localparam int unsigned IFU_FQ_DEPTH_SMALL   = 2;
  localparam int unsigned IFU_FQ_DEPTH_LARGE   = 4;
  localparam int unsigned IFU_FQ_DEPTH_DEFAULT = IFU_FQ_DEPTH_SMALL;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_WAIT_RSP = 2'd2
  } ifu_state_e;

  // True for a queue depth the fetch unit can be built with
  function automatic bit fq_depth_legal(input int unsigned depth);
    return (depth == IFU_FQ_DEPTH_SMALL) || (depth == IFU_FQ_DEPTH_LARGE);
  endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// rtl/ifu_fetch_fifo.sv - fetch queue holding {pc, instruction} pairs, head shown combinationally
module ifu_fetch_fifo
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned XLEN  = IFU_XLEN,
  parameter int unsigned DEPTH = IFU_FQ_DEPTH_DEFAULT,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic [XLEN-1:0] push_data,
  input  logic            pop,
  input  logic            clear,
  output logic [CW-1:0]   count,
  output logic            head_valid,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_data
);

  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [XLEN-1:0] pc_mem_d   [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];
  logic [XLEN-1:0] data_mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;
  logic            full;

  assign full       = (count_q == CW'(DEPTH));
  assign head_valid = (count_q != '0);
  assign do_pop     = pop && head_valid;
  // A push into a full queue is accepted only when the head leaves in the same cycle
  assign do_push    = push && (!full || do_pop);

  assign count     = count_q;
  assign head_pc   = pc_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; clear wins over push/pop
  always_comb begin
    pc_mem_d   = pc_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        pc_mem_d[wr_ptr_q]   = push_pc;
        data_mem_d[wr_ptr_q] = push_data;
        wr_ptr_d             = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Queue state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_mem_q   <= pc_mem_d;
      data_mem_q <= data_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch sequencer; IFU_ALIGN_CHECK_EN enables redirect alignment check
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned XLEN     = IFU_XLEN,
  parameter int unsigned FQ_DEPTH = IFU_FQ_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_addr,
  output logic            pc_write_en,
  output logic [XLEN-1:0] pc_write_addr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_addr,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            misalign_err
);

  // Unsupported depths fall back to the default rather than building a broken queue
  localparam int unsigned DEPTH = fq_depth_legal(FQ_DEPTH) ? FQ_DEPTH : IFU_FQ_DEPTH_DEFAULT;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  ifu_state_e      state_q, state_d;
  logic            discard_q, discard_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [XLEN-1:0] hold_data_q, hold_data_d;

  logic            flush_act;
  logic            outstanding;
  logic [CW:0]     occupancy;
  logic            issue;
  logic            fq_push, fq_pop;
  logic [CW-1:0]   fq_count;
  logic            fq_valid;
  logic [XLEN-1:0] fq_head_pc, fq_head_data;
  logic [XLEN-1:0] redirect_pc;
  logic            misaligned;

  // A flush seen while reset is asserted must not disturb the zeroed outputs
  assign flush_act = flush && rst_n;

  // A discarded response still occupies the single outstanding slot
  assign outstanding = (state_q == ST_WAIT_RSP) || discard_q;
  assign occupancy   = {1'b0, fq_count} + (CW+1)'(outstanding);
  assign issue       = (state_q == ST_FETCH) && !flush_act && !discard_q
                       && (occupancy < (CW+1)'(DEPTH));

  // Only a live response in WAIT_RSP enters the queue; flush drops it
  assign fq_push = (state_q == ST_WAIT_RSP) && imem_rvalid && !flush_act;
  assign fq_pop  = fq_valid && inst_ready && !flush_act;

`ifdef IFU_ALIGN_CHECK_EN
  assign misaligned  = flush_act && (flush_addr[1:0] != 2'b00);
  assign redirect_pc = {flush_addr[XLEN-1:2], 2'b00};
`else
  assign misaligned  = 1'b0;
  assign redirect_pc = flush_addr;
`endif

  assign misalign_err = misaligned;

  // PC write and memory request strobes; a redirect overrides a sequential issue
  always_comb begin
    pc_write_en   = 1'b0;
    pc_write_addr = '0;
    imem_req      = 1'b0;
    imem_addr     = '0;
    if (flush_act) begin
      pc_write_en   = 1'b1;
      pc_write_addr = redirect_pc;
    end else if (issue) begin
      pc_write_en   = 1'b1;
      pc_write_addr = pc_addr + XLEN'(IFU_PC_INC);
      imem_req      = 1'b1;
      imem_addr     = pc_addr;
    end
  end

  // Sequencer next state, outstanding address and stale-response tracking
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    req_pc_d  = req_pc_q;
    case (state_q)
      ST_IDLE:     state_d = ST_FETCH;
      ST_FETCH: begin
        if (issue) begin
          state_d  = ST_WAIT_RSP;
          req_pc_d = pc_addr;
        end
      end
      ST_WAIT_RSP: if (imem_rvalid) state_d = ST_FETCH;
      default:     state_d = ST_IDLE;
    endcase
    // The response to a redirected-away request is consumed here and dropped
    if (discard_q && imem_rvalid) discard_d = 1'b0;
    if (flush_act) begin
      state_d = ST_FETCH;
      if ((state_q == ST_WAIT_RSP) && !imem_rvalid) discard_d = 1'b1;
    end
  end

  // Keep the last presented head so the decoder sees stable values when the queue drains
  always_comb begin
    hold_pc_d   = hold_pc_q;
    hold_data_d = hold_data_q;
    if (fq_valid) begin
      hold_pc_d   = fq_head_pc;
      hold_data_d = fq_head_data;
    end
  end

  assign inst_valid = fq_valid;
  assign inst_pc    = fq_valid ? fq_head_pc   : hold_pc_q;
  assign inst_data  = fq_valid ? fq_head_data : hold_data_q;

  // Sequencer and holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      discard_q   <= 1'b0;
      req_pc_q    <= '0;
      hold_pc_q   <= '0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      req_pc_q    <= req_pc_d;
      hold_pc_q   <= hold_pc_d;
      hold_data_q <= hold_data_d;
    end
  end

  ifu_fetch_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fq_push),
    .push_pc    (req_pc_q),
    .push_data  (imem_rdata),
    .pop        (fq_pop),
    .clear      (flush_act),
    .count      (fq_count),
    .head_valid (fq_valid),
    .head_pc    (fq_head_pc),
    .head_data  (fq_head_data)
  );

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed self-checking bench for ifu_fetch
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_q = 32'h0;
  logic        pc_write_en;
  logic [31:0] pc_write_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] flush_addr = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        misalign_err;

  logic        pc_load = 1'b0;
  logic [31:0] pc_init = 32'h0;
  logic        ram_kill = 1'b0;
  int          ram_lat = 1;
  int          ram_cnt = 0;
  logic [31:0] ram_addr = 32'h0;

  int checks = 0;
  int failures = 0;

`ifdef IFU_ALIGN_CHECK_EN
  localparam logic        EXP_MIS   = 1'b1;
  localparam logic [31:0] EXP_REDIR = 32'h0000_0100;
`else
  localparam logic        EXP_MIS   = 1'b0;
  localparam logic [31:0] EXP_REDIR = 32'h0000_0102;
`endif

  ifu_fetch #(.XLEN(32), .FQ_DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_addr       (pc_q),
    .pc_write_en   (pc_write_en),
    .pc_write_addr (pc_write_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .flush         (flush),
    .flush_addr    (flush_addr),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // PC register model
  always @(posedge clk) begin
    if (pc_load) pc_q <= pc_init;
    else if (pc_write_en) pc_q <= pc_write_addr;
  end

  // Instruction RAM model with ram_lat cycles of latency; not reset by rst_n
  always @(posedge clk) begin
    imem_rvalid <= 1'b0;
    if (ram_kill) begin
      ram_cnt <= 0;
    end else if (imem_req) begin
      if (ram_lat <= 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= rd_of(imem_addr);
        ram_cnt     <= 0;
      end else begin
        ram_cnt  <= ram_lat - 1;
        ram_addr <= imem_addr;
      end
    end else if (ram_cnt != 0) begin
      ram_cnt <= ram_cnt - 1;
      if (ram_cnt == 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= rd_of(ram_addr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat, input logic [31:0] start_pc);
    rst_n = 1'b0; flush = 1'b0; flush_addr = 32'h0; inst_ready = 1'b0;
    ram_kill = 1'b1; pc_load = 1'b1; pc_init = start_pc; ram_lat = lat;
    repeat (2) tick();
    ram_kill = 1'b0; pc_load = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b1; flush_addr = 32'h55; inst_ready = 1'b1;
    pc_load = 1'b1; pc_init = 32'h40; ram_kill = 1'b1;
    repeat (2) tick();
    #1;
    checks++;
    if ({pc_write_en, imem_req, inst_valid, misalign_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=0000", {pc_write_en, imem_req, inst_valid, misalign_err});
    end
    checks++;
    if (pc_write_addr !== 32'h0 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_addrs got=%h/%h exp=0/0", pc_write_addr, imem_addr);
    end
    checks++;
    if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_inst got=%h/%h exp=0/0", inst_data, inst_pc);
    end
    flush = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] req_a [3];
    int          req_c [3];
    logic [31:0] pop_pc [3];
    logic [31:0] pop_d [3];
    int nreq = 0;
    int npop = 0;
    int bad_we = 0;
    do_reset(1, 32'h0);
    inst_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick(); #1;
      if (imem_req && nreq < 3) begin req_a[nreq] = imem_addr; req_c[nreq] = c; nreq++; end
      if (inst_valid && npop < 3) begin pop_pc[npop] = inst_pc; pop_d[npop] = inst_data; npop++; end
      if (pc_write_en !== imem_req) bad_we++;
    end
    checks++;
    if (nreq != 3 || npop != 3) begin
      failures++;
      $display("FAIL seq_counts got=%0d/%0d exp=3/3", nreq, npop);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (req_a[i] !== 32'(4 * i) || pop_pc[i] !== 32'(4 * i) || pop_d[i] !== rd_of(32'(4 * i))) begin
          failures++;
          $display("FAIL seq_entry%0d got=%h/%h/%h exp=%h", i, req_a[i], pop_pc[i], pop_d[i], 32'(4 * i));
        end
      end
      checks++;
      if (req_c[0] != 0 || req_c[1] != 2 || req_c[2] != 4) begin
        failures++;
        $display("FAIL seq_spacing got=%0d,%0d,%0d exp=0,2,4", req_c[0], req_c[1], req_c[2]);
      end
    end
    checks++;
    if (bad_we != 0) begin
      failures++;
      $display("FAIL seq_pc_write_en got=%0d exp=0 stray cycles", bad_we);
    end
  endtask

  task automatic test_full();
    int nreq = 0;
    do_reset(1, 32'h0);
    for (int c = 0; c < 10; c++) begin
      tick(); #1;
      if (imem_req) nreq++;
    end
    checks++;
    if (nreq != 2 || inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      failures++;
      $display("FAIL full_requests got=%0d valid=%b pc=%h exp=2 1 0", nreq, inst_valid, inst_pc);
    end
    tick(); inst_ready = 1'b1; #1;
    checks++;
    if (imem_req !== 1'b0 || inst_pc !== 32'h0) begin
      failures++;
      $display("FAIL full_pop_cycle got=req%b pc%h exp=req0 pc0", imem_req, inst_pc);
    end
    tick(); inst_ready = 1'b0; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      failures++;
      $display("FAIL full_after_pop got=req%b addr%h exp=req1 addr8", imem_req, imem_addr);
    end
  endtask

  task automatic test_flush_outstanding();
    logic found = 1'b0;
    int req_cyc = -1;
    logic [31:0] req_addr = 32'hffff_ffff;
    logic got_pop = 1'b0;
    logic [31:0] p_pc = 32'h0;
    logic [31:0] p_d = 32'h0;
    do_reset(3, 32'h0);
    inst_ready = 1'b1;
    for (int c = 0; c < 30 && !found; c++) begin
      tick(); #1;
      if (imem_req && imem_addr == 32'h8) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL fo_req8 got=none exp=request at 0x8");
    end
    tick(); flush = 1'b1; flush_addr = 32'h100; #1;
    checks++;
    if (pc_write_en !== 1'b1 || pc_write_addr !== 32'h100 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL fo_flush_cycle got=we%b addr%h req%b exp=we1 addr100 req0", pc_write_en, pc_write_addr, imem_req);
    end
    for (int c = 0; c < 30 && !got_pop; c++) begin
      tick(); flush = 1'b0; #1;
      if (imem_req && req_cyc < 0) begin req_cyc = c; req_addr = imem_addr; end
      if (inst_valid) begin got_pop = 1'b1; p_pc = inst_pc; p_d = inst_data; end
    end
    checks++;
    if (req_cyc != 2 || req_addr !== 32'h100) begin
      failures++;
      $display("FAIL fo_next_req got=cyc%0d addr%h exp=cyc2 addr100", req_cyc, req_addr);
    end
    checks++;
    if (!got_pop || p_pc !== 32'h100 || p_d !== rd_of(32'h100)) begin
      failures++;
      $display("FAIL fo_first_inst got=%b pc%h data%h exp=1 pc100 data%h", got_pop, p_pc, p_d, rd_of(32'h100));
    end
  endtask

  task automatic test_flush_pop();
    logic found = 1'b0;
    do_reset(1, 32'h0);
    for (int c = 0; c < 10 && !found; c++) begin
      tick(); #1;
      if (inst_valid) found = 1'b1;
    end
    flush = 1'b1; flush_addr = 32'h40; inst_ready = 1'b1; #1;
    checks++;
    if (!found || pc_write_en !== 1'b1 || pc_write_addr !== 32'h40 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL fp_flush_cycle got=found%b we%b addr%h req%b exp=1 1 40 0", found, pc_write_en, pc_write_addr, imem_req);
    end
    tick(); flush = 1'b0; inst_ready = 1'b0; #1;
    checks++;
    if (inst_valid !== 1'b0 || inst_pc !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      failures++;
      $display("FAIL fp_after got=v%b pc%h req%b addr%h exp=v0 pc0 req1 addr40", inst_valid, inst_pc, imem_req, imem_addr);
    end
    repeat (2) tick();
    #1;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin
      failures++;
      $display("FAIL fp_refill got=v%b pc%h exp=v1 pc40", inst_valid, inst_pc);
    end
  endtask

  task automatic test_misalign();
    do_reset(1, 32'h0);
    tick(); flush = 1'b1; flush_addr = 32'h102; #1;
    checks++;
    if (misalign_err !== EXP_MIS || pc_write_addr !== EXP_REDIR || pc_write_en !== 1'b1) begin
      failures++;
      $display("FAIL mis_flush got=err%b addr%h we%b exp=err%b addr%h we1", misalign_err, pc_write_addr, pc_write_en, EXP_MIS, EXP_REDIR);
    end
    tick(); flush = 1'b0; #1;
    checks++;
    if (misalign_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== EXP_REDIR) begin
      failures++;
      $display("FAIL mis_after got=err%b req%b addr%h exp=err0 req1 addr%h", misalign_err, imem_req, imem_addr, EXP_REDIR);
    end
    tick(); flush = 1'b1; flush_addr = 32'h200; #1;
    checks++;
    if (misalign_err !== 1'b0 || pc_write_addr !== 32'h200) begin
      failures++;
      $display("FAIL mis_aligned got=err%b addr%h exp=err0 addr200", misalign_err, pc_write_addr);
    end
    tick(); flush = 1'b0;
  endtask

  task automatic test_pc_wrap();
    do_reset(1, 32'hffff_fffc);
    tick(); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hffff_fffc || pc_write_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap got=req%b addr%h next%h exp=req1 addrfffffffc next0", imem_req, imem_addr, pc_write_addr);
    end
  endtask

  task automatic test_reset_midreq();
    logic found = 1'b0;
    do_reset(3, 32'h0);
    tick(); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL rm_first_req got=req%b addr%h exp=req1 addr0", imem_req, imem_addr);
    end
    tick(); rst_n = 1'b0; #1;
    checks++;
    if ({imem_req, pc_write_en, inst_valid} !== 3'b000) begin
      failures++;
      $display("FAIL rm_in_reset got=%b exp=000", {imem_req, pc_write_en, inst_valid});
    end
    tick(); rst_n = 1'b1;
    tick(); #1;
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      failures++;
      $display("FAIL rm_stray_cycle got=v%b req%b addr%h exp=v0 req1 addr4", inst_valid, imem_req, imem_addr);
    end
    tick(); #1;
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL rm_after_stray got=v%b exp=v0", inst_valid);
    end
    for (int c = 0; c < 10 && !found; c++) begin
      tick(); #1;
      if (inst_valid) found = 1'b1;
    end
    checks++;
    if (!found || inst_pc !== 32'h4 || inst_data !== rd_of(32'h4)) begin
      failures++;
      $display("FAIL rm_first_inst got=%b pc%h data%h exp=1 pc4 data%h", found, inst_pc, inst_data, rd_of(32'h4));
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_full();
    test_flush_outstanding();
    test_flush_pop();
    test_misalign();
    test_pc_wrap();
    test_reset_midreq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
